// File: rtl/hls_run_seq_pkg.sv
// Shared types for the HLS run sequencer: FSM state encoding, result status
// codes and the default-width result record.
package hls_run_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRST   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t STATUS_PASS    = 2'b01;
    localparam status_t STATUS_TIMEOUT = 2'b10;

    // Cycle-field width of the result record at the default CNT_W.
    localparam int RESULT_CNT_W = 32;

    // One result word as it leaves the FIFO: {status, cycles}.
    typedef struct packed {
        status_t                 status;
        logic [RESULT_CNT_W-1:0] cycles;
    } run_result_t;

endpackage

// File: rtl/hls_run_seq_fifo.sv
// First-word-fall-through result FIFO. Depth must be a power of two so the
// pointers wrap for free. A push into a full FIFO is accepted only when a pop
// happens in the same cycle, so nothing is ever overwritten or dropped.
module hls_run_seq_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/hls_run_sequencer.sv
// Batch sequencer for an HLS accelerator: resets, starts and times each run,
// and queues one {status, cycles} result per run in a FWFT FIFO.
// Optional feature macro: HLS_RUN_SEQ_STATS_EN adds stat_min/stat_max/stat_fail.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid does not wait for ready, and ready may depend on state.
module hls_run_sequencer
    import hls_run_seq_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int RUNS_W    = 8,
    parameter int RES_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [RUNS_W-1:0] cfg_runs,
    input  logic [CNT_W-1:0]  cfg_timeout,
    output logic              dut_reset,
    output logic              dut_start,
    input  logic              dut_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W+1:0]  res_data,
    output logic              busy,
    output logic              batch_done
`ifdef HLS_RUN_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [RUNS_W-1:0] stat_fail
`endif
);

    localparam int RES_W = CNT_W + 2;

    state_t            state_q;
    state_t            state_d;
    logic              drst_cnt_q;
    logic [RUNS_W-1:0] runs_left_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  counter_q;
    logic [CNT_W-1:0]  counter_inc;
    status_t           res_status_q;
    logic [CNT_W-1:0]  res_cycles_q;
    logic              batch_done_q;

    logic              accept;
    logic              zero_batch;
    logic              capture;
    logic              capture_pass;
    logic [CNT_W-1:0]  capture_cycles;
    logic              batch_end;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [RES_W-1:0]  fifo_dout;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign counter_inc = (counter_q == '1) ? counter_q : counter_q + 1'b1;

    // Outputs are forced inactive while reset is held low.
    assign cfg_ready  = reset && (state_q == ST_IDLE);
    assign busy       = reset && (state_q != ST_IDLE);
    assign dut_start  = reset && (state_q == ST_LAUNCH);
    assign dut_reset  = reset && (state_q != ST_DRST);
    assign res_valid  = reset && !fifo_empty;
    assign batch_done = reset && batch_done_q;
    assign res_data   = fifo_dout;
    assign fifo_pop   = res_valid && res_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        zero_batch     = 1'b0;
        capture        = 1'b0;
        capture_pass   = 1'b0;
        capture_cycles = '0;
        fifo_push      = 1'b0;
        batch_end      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_runs != '0) begin
                        accept  = 1'b1;
                        state_d = ST_DRST;
                    end else begin
                        zero_batch = 1'b1;
                    end
                end
            end
            ST_DRST: begin
                if (drst_cnt_q) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (dut_done) begin
                    capture        = 1'b1;
                    capture_pass   = 1'b1;
                    capture_cycles = CNT_W'(1);
                    state_d        = ST_REPORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion wins over a coincident timeout.
                if (dut_done) begin
                    capture        = 1'b1;
                    capture_pass   = 1'b1;
                    capture_cycles = counter_inc;
                    state_d        = ST_REPORT;
                end else if (counter_q == timeout_q) begin
                    capture        = 1'b1;
                    capture_cycles = timeout_q;
                    state_d        = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    if (runs_left_q == RUNS_W'(1)) begin
                        batch_end = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (res_status_q == STATUS_TIMEOUT) begin
                        state_d = ST_DRST;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Batch configuration, run counter, captured result and done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            drst_cnt_q   <= 1'b0;
            runs_left_q  <= '0;
            timeout_q    <= '0;
            counter_q    <= '0;
            res_status_q <= '0;
            res_cycles_q <= '0;
            batch_done_q <= 1'b0;
        end else begin
            batch_done_q <= zero_batch || batch_end;
            drst_cnt_q   <= (state_q == ST_DRST) ? ~drst_cnt_q : 1'b0;
            if (accept) begin
                runs_left_q <= cfg_runs;
                timeout_q   <= cfg_timeout;
            end else if (fifo_push) begin
                runs_left_q <= runs_left_q - 1'b1;
            end
            if (state_q == ST_LAUNCH)    counter_q <= CNT_W'(1);
            else if (state_q == ST_WAIT) counter_q <= counter_inc;
            if (capture) begin
                res_status_q <= capture_pass ? STATUS_PASS : STATUS_TIMEOUT;
                res_cycles_q <= capture_cycles;
            end
        end
    end

`ifdef HLS_RUN_SEQ_STATS_EN
    // Per-batch statistics, updated as each result is queued.
    always_ff @(posedge clock) begin
        if (!reset || accept) begin
            stat_min  <= '1;
            stat_max  <= '0;
            stat_fail <= '0;
        end else if (fifo_push) begin
            if (res_status_q == STATUS_PASS) begin
                if (res_cycles_q < stat_min) stat_min <= res_cycles_q;
                if (res_cycles_q > stat_max) stat_max <= res_cycles_q;
            end else if (stat_fail != '1) begin
                stat_fail <= stat_fail + 1'b1;
            end
        end
    end
`endif

    hls_run_seq_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({res_status_q, res_cycles_q}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer (default build, RES_DEPTH=2).
// A responder raises dut_done on the Nth cycle of a run, counting the
// dut_start cycle as 1, with N taken from done_tab (0 = never).
module tb_hls_run_sequencer;
  import hls_run_seq_pkg::*;

  localparam int CNT_W     = 32;
  localparam int RUNS_W    = 8;
  localparam int RES_DEPTH = 2;
  localparam int RES_W     = CNT_W + 2;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [RUNS_W-1:0] cfg_runs = '0;
  logic [CNT_W-1:0]  cfg_timeout = '0;
  logic              dut_reset;
  logic              dut_start;
  logic              dut_done = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RES_W-1:0]  res_data;
  logic              busy;
  logic              batch_done;

  always #5 clock = ~clock;

  hls_run_sequencer #(
    .CNT_W     (CNT_W),
    .RUNS_W    (RUNS_W),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_runs    (cfg_runs),
    .cfg_timeout (cfg_timeout),
    .dut_reset   (dut_reset),
    .dut_start   (dut_start),
    .dut_done    (dut_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .batch_done  (batch_done)
  );

  // ---------------- scoreboard state ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int done_tab[8];
  int tab_base     = 0;
  int starts_total = 0;
  int bd_total     = 0;
  int rst_low_at[64];
  int rst_low_run  = 0;
  int k            = 0;
  int cur_delay    = 0;

  // Monitor and accelerator responder, sampled mid-cycle.
  always @(negedge clock) begin
    if (res_valid && res_ready) obs_q.push_back(res_data);
    if (batch_done) bd_total++;
    if (!reset) begin
      k = 0;
      dut_done = 1'b0;
      rst_low_run = 0;
    end else begin
      if (!dut_reset) rst_low_run++;
      if (dut_start) begin
        if (starts_total < 64) rst_low_at[starts_total] = rst_low_run;
        rst_low_run = 0;
        cur_delay = done_tab[(starts_total - tab_base) % 8];
        starts_total++;
        k = 1;
      end else if (k > 0) begin
        k++;
      end
      dut_done = (k > 0) && (k == cur_delay);
      if (dut_done) k = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cfg(input int runs, input int timeout);
    cfg_runs    = RUNS_W'(runs);
    cfg_timeout = CNT_W'(timeout);
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_bd(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bd_total >= target) ok = 1;
      else tick();
    end
    if (bd_total >= target) ok = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    n_checks++; if (dut_start !== 1'b0)  begin n_fail++; $display("FAIL rst_dut_start got %b want 0", dut_start); end
    n_checks++; if (dut_reset !== 1'b0)  begin n_fail++; $display("FAIL rst_dut_reset got %b want 0", dut_reset); end
    n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    n_checks++; if (batch_done !== 1'b0) begin n_fail++; $display("FAIL rst_batch_done got %b want 0", batch_done); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (cfg_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cfg_ready got %b want 1", cfg_ready); end
    n_checks++; if (dut_reset !== 1'b1) begin n_fail++; $display("FAIL post_rst_dut_reset got %b want 1", dut_reset); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL post_rst_busy got %b want 0", busy); end
    tick();
  endtask

  // Three runs, done on cycle 10 of each, generous timeout.
  task automatic test_pass_batch();
    int s0, b0; bit ok;
    s0 = starts_total; b0 = bd_total; tab_base = starts_total;
    done_tab = '{10, 10, 10, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    repeat (3) exp_q.push_back({STATUS_PASS, 32'd10});
    res_ready = 1'b1;
    issue_cfg(3, 100);
    wait_bd(b0 + 1, 300, ok);
    repeat (4) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pass_batch_done got timeout want pulse"); end
    n_checks++; if (bd_total - b0 != 1) begin n_fail++; $display("FAIL pass_bd_count got %0d want 1", bd_total - b0); end
    n_checks++; if (starts_total - s0 != 3) begin n_fail++; $display("FAIL pass_starts got %0d want 3", starts_total - s0); end
    n_checks++; if (rst_low_at[s0] != 2) begin n_fail++; $display("FAIL pass_rst_first got %0d want 2", rst_low_at[s0]); end
    n_checks++; if (rst_low_at[s0+1] != 0) begin n_fail++; $display("FAIL pass_rst_second got %0d want 0", rst_low_at[s0+1]); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pass_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pass_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // Single run that never completes.
  task automatic test_timeout();
    int b0; bit ok;
    b0 = bd_total; tab_base = starts_total;
    done_tab = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_TIMEOUT, 32'd20});
    issue_cfg(1, 20);
    wait_bd(b0 + 1, 200, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_batch_done got timeout want pulse"); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL to_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL to_res got %h want %h", obs_q[0], exp_q[0]); end
    end
  endtask

  // Timeout on run 1 forces a fresh accelerator reset before run 2.
  task automatic test_timeout_retry();
    int s0, b0; bit ok;
    s0 = starts_total; b0 = bd_total; tab_base = starts_total;
    done_tab = '{0, 3, 0, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_TIMEOUT, 32'd5});
    exp_q.push_back({STATUS_PASS, 32'd3});
    issue_cfg(2, 5);
    wait_bd(b0 + 1, 200, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_batch_done got timeout want pulse"); end
    n_checks++; if (rst_low_at[s0+1] != 2) begin n_fail++; $display("FAIL retry_rst_cycles got %0d want 2", rst_low_at[s0+1]); end
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL retry_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL retry_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // timeout=7: done on cycle 7 gives PASS 7; done on cycle 8 lands while the
  // counter equals the timeout, and completion wins with cycles = 7 + 1.
  task automatic test_done_vs_timeout();
    int b0; bit ok;
    b0 = bd_total; tab_base = starts_total;
    done_tab = '{7, 8, 0, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_PASS, 32'd7});
    exp_q.push_back({STATUS_PASS, 32'd8});
    issue_cfg(2, 7);
    wait_bd(b0 + 1, 200, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL dvt_batch_done got timeout want pulse"); end
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL dvt_count got %0d want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dvt_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // Done during the start cycle itself.
  task automatic test_launch_done();
    int b0; bit ok;
    b0 = bd_total; tab_base = starts_total;
    done_tab = '{1, 0, 0, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_PASS, 32'd1});
    issue_cfg(1, 10);
    wait_bd(b0 + 1, 100, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL launch_batch_done got timeout want pulse"); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL launch_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL launch_res got %h want %h", obs_q[0], exp_q[0]); end
    end
  endtask

  // cfg_runs = 0: consumed, no launch, one-cycle batch_done next cycle.
  task automatic test_zero_runs();
    int s0;
    s0 = starts_total;
    issue_cfg(0, 10);
    @(negedge clock);
    n_checks++; if (batch_done !== 1'b1) begin n_fail++; $display("FAIL zero_bd got %b want 1", batch_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
    @(negedge clock);
    n_checks++; if (batch_done !== 1'b0) begin n_fail++; $display("FAIL zero_bd_width got %b want 0", batch_done); end
    repeat (10) tick();
    n_checks++; if (starts_total != s0) begin n_fail++; $display("FAIL zero_starts got %0d want %0d", starts_total, s0); end
  endtask

  // cfg_valid held while busy must not start a second batch.
  task automatic test_busy_ignore();
    int s0, b0; bit ok;
    s0 = starts_total; b0 = bd_total; tab_base = starts_total;
    done_tab = '{4, 4, 4, 4, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_PASS, 32'd4});
    issue_cfg(1, 12);
    cfg_runs = 8'd3; cfg_valid = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", busy); end
    cfg_valid = 1'b0;
    wait_bd(b0 + 1, 100, ok);
    repeat (10) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_batch_done got timeout want pulse"); end
    n_checks++; if (starts_total - s0 != 1) begin n_fail++; $display("FAIL ign_starts got %0d want 1", starts_total - s0); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL ign_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL ign_res got %h want %h", obs_q[0], exp_q[0]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle got %b want 0", busy); end
  endtask

  // Depth-2 FIFO with res_ready low: third result stalls REPORT, then all
  // five drain in order once res_ready is raised.
  task automatic test_back_to_back();
    int s0, b0; bit ok;
    s0 = starts_total; b0 = bd_total; tab_base = starts_total;
    done_tab = '{2, 3, 4, 5, 6, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    for (int i = 2; i <= 6; i++) exp_q.push_back({STATUS_PASS, CNT_W'(i)});
    res_ready = 1'b0;
    issue_cfg(5, 50);
    repeat (40) tick();
    n_checks++; if (starts_total - s0 != 3) begin n_fail++; $display("FAIL bp_stall_starts got %0d want 3", starts_total - s0); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_busy got %b want 1", busy); end
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid got %b want 1", res_valid); end
    n_checks++; if (res_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got %h want %h", res_data, exp_q[0]); end
    res_ready = 1'b1;
    wait_bd(b0 + 1, 200, ok);
    repeat (6) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_batch_done got timeout want pulse"); end
    n_checks++; if (obs_q.size() != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_res[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // Reset during WAIT of run 2 of 4 aborts the batch and drops the result.
  task automatic test_abort();
    int s0, b0, n; bit seen;
    s0 = starts_total; b0 = bd_total; tab_base = starts_total;
    done_tab = '{5, 5, 5, 5, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    res_ready = 1'b0;
    issue_cfg(4, 50);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (starts_total - s0 >= 2) seen = 1;
      else tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_run2 got timeout want second start"); end
    repeat (2) tick();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pre_valid got %b want 1", res_valid); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_in_rst_busy got %b want 0", busy); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL abort_cfg_ready got %b want 1", cfg_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_res_valid got %b want 0", res_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    res_ready = 1'b1;
    n = starts_total;
    repeat (30) tick();
    n_checks++; if (starts_total != n) begin n_fail++; $display("FAIL abort_starts got %0d want %0d", starts_total, n); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_results got %0d want 0", obs_q.size()); end
    n_checks++; if (bd_total != b0) begin n_fail++; $display("FAIL abort_bd got %0d want %0d", bd_total, b0); end
  endtask

  // A fresh batch after the abort behaves normally.
  task automatic test_after_abort();
    int b0; bit ok;
    b0 = bd_total; tab_base = starts_total;
    done_tab = '{3, 0, 0, 0, 0, 0, 0, 0};
    exp_q.delete(); obs_q.delete();
    exp_q.push_back({STATUS_PASS, 32'd3});
    issue_cfg(1, 9);
    wait_bd(b0 + 1, 100, ok);
    repeat (3) tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_abort_bd got timeout want pulse"); end
    n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL post_abort_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL post_abort_res got %h want %h", obs_q[0], exp_q[0]); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_pass_batch();
    test_timeout();
    test_timeout_retry();
    test_done_vs_timeout();
    test_launch_done();
    test_zero_runs();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_after_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
